// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader side is the slave; the host/byte link and memory port side is the master.
interface instr_mem_loader_if;
   // A byte moves on a rising edge when byte_valid && byte_ready. The loader
   // raises byte_ready from its state alone. The source holds byte_data stable
   // until the transfer completes.
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        InsMemRW;
   logic [15:0] IAddress;
   logic [15:0] IData;

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output InsMemRW,
      output IAddress,
      output IData
   );

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  InsMemRW,
      input  IAddress,
      input  IData
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads instruction memory from a little-endian byte stream: a 16-bit word
// count, then that many 16-bit words, each written to the next address.
module instr_mem_loader #(
   parameter int DEPTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   instr_mem_loader_if.slave         bus,
   output logic                      busy,
   output logic                      cpu_hold,
   output logic                      done,
   output logic                      err,
   output logic [2:0]                dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_LO = 3'd1,
      HDR_HI = 3'd2,
      DAT_LO = 3'd3,
      DAT_HI = 3'd4,
      WRITE  = 3'd5,
      DONE   = 3'd6,
      ERR    = 3'd7
   } state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] count;
   logic [6:0]  counter;
   logic [6:0]  counter_inc;
   logic [15:0] hdr_count;
   logic [15:0] addr;
   logic [15:0] data;
   logic        xfer;
   logic        idle_like;
   logic        can_start;

   assign idle_like   = (state == IDLE) || (state == DONE) || (state == ERR);
   assign can_start   = start && idle_like;
   assign xfer        = bus.byte_valid && bus.byte_ready;
   assign counter_inc = counter + 7'd1;
   assign hdr_count   = {bus.byte_data, count[7:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) state_nxt = HDR_LO;
         end
         HDR_LO: begin
            if (xfer) state_nxt = HDR_HI;
         end
         HDR_HI: begin
            if (xfer) begin
               if (hdr_count == 16'd0)                 state_nxt = DONE;
               else if ({1'b0, hdr_count} > DEPTH_W)   state_nxt = ERR;
               else                                    state_nxt = DAT_LO;
            end
         end
         DAT_LO: begin
            if (xfer) state_nxt = DAT_HI;
         end
         DAT_HI: begin
            if (xfer) state_nxt = WRITE;
         end
         WRITE: begin
            if ({9'b0, counter_inc} == count) state_nxt = DONE;
            else                              state_nxt = DAT_LO;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The address is captured with the high byte so that it still shows the
   // last written word after the counter has moved on.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 16'd0;
         counter <= 7'd0;
         addr    <= 16'd0;
         data    <= 16'd0;
      end else begin
         if (can_start) begin
            count   <= 16'd0;
            counter <= 7'd0;
            addr    <= 16'd0;
         end
         if (xfer) begin
            case (state)
               HDR_LO: count[7:0]  <= bus.byte_data;
               HDR_HI: count[15:8] <= bus.byte_data;
               DAT_LO: data[7:0]   <= bus.byte_data;
               DAT_HI: begin
                  data[15:8] <= bus.byte_data;
                  addr       <= {9'b0, counter};
               end
               default: ;
            endcase
         end
         if (state == WRITE) counter <= counter_inc;
      end
   end

   assign bus.byte_ready = (state == HDR_LO) || (state == HDR_HI) ||
                           (state == DAT_LO) || (state == DAT_HI);
   assign bus.InsMemRW   = (state == WRITE);
   assign bus.IAddress   = addr;
   assign bus.IData      = data;
   assign busy           = !idle_like;
   assign cpu_hold       = !idle_like;
   assign done           = (state == DONE);
   assign err            = (state == ERR);
   assign dbg_state      = state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of load sessions plus randomized sessions,
// checked by a stream-level model and a write scoreboard.
module tb_instr_mem_loader;

   localparam int DEPTH = 64;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       cpu_hold;
   logic       done;
   logic       err;
   logic [2:0] dbg_state;

   instr_mem_loader_if bus ();

   instr_mem_loader #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (bus.slave),
      .busy      (busy),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int n_strobe = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  stream_q[$];
   logic [15:0] fixed_w[3] = '{16'h1234, 16'h5678, 16'h9ABC};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.InsMemRW === 1'b1) begin
         n_strobe++;
         check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got addr %0h data %0h, required no write",
                     bus.IAddress, bus.IData);
         end else begin
            check("strobe_addr_data", {bus.IAddress, bus.IData}, exp_q.pop_front());
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic build_stream(input int count, input int kind);
      logic [15:0] w;
      stream_q.delete();
      stream_q.push_back(8'(count));
      stream_q.push_back(8'(count >> 8));
      if (count <= DEPTH) begin
         for (int k = 0; k < count; k++) begin
            if (kind == 1)      w = fixed_w[k % 3];
            else if (kind == 2) w = 16'hBEEF;
            else                w = 16'($urandom);
            stream_q.push_back(w[7:0]);
            stream_q.push_back(w[15:8]);
         end
      end
   endtask

   // Word k of the stream lands at address k; an oversized count writes nothing.
   task automatic model_expect(output bit m_err, output int m_n);
      int cnt;
      cnt = int'(stream_q[1]) * 256 + int'(stream_q[0]);
      exp_q.delete();
      m_err = (cnt > DEPTH);
      m_n   = m_err ? 0 : cnt;
      for (int k = 0; k < m_n; k++)
         exp_q.push_back({16'(k), stream_q[3 + 2*k], stream_q[2 + 2*k]});
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_bytes(input int n_lim, input int gap, input bit poke);
      int idx = 0;
      int n = 0;
      bit poked = 1'b0;
      while (idx < n_lim && n < 4000) begin
         bus.byte_valid = ($urandom_range(0, 99) >= gap);
         bus.byte_data  = stream_q[idx];
         start = poke && !poked && (idx == 4);
         if (start) poked = 1'b1;
         if (bus.byte_valid && bus.byte_ready) idx++;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("send_bytes_consumed", 32'(idx), 32'(n_lim));
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_bound", 32'(busy), 32'd0);
   endtask

   task automatic run_session(input int count, input int gap, input bit poke, input int kind,
                              input bit use_tab, input bit t_done, input bit t_err, input int t_n);
      bit m_err;
      int m_n;
      bit e_done;
      bit e_err;
      int e_n;
      int c0;
      int c1;
      int strobes_end;
      build_stream(count, kind);
      model_expect(m_err, m_n);
      e_done = use_tab ? t_done : !m_err;
      e_err  = use_tab ? t_err  : m_err;
      e_n    = use_tab ? t_n    : m_n;
      n_strobe = 0;
      bus.byte_valid = 1'b0;
      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(bus.byte_ready), 32'd1);
      check("start_clears_flags", {30'd0, done, err}, 32'd0);
      check("start_clears_addr", 32'(bus.IAddress), 32'd0);
      c0 = cyc;
      send_bytes(stream_q.size(), gap, poke);
      bus.byte_valid = 1'b0;
      wait_idle(400);
      c1 = cyc;
      check("end_done", 32'(done), 32'(e_done));
      check("end_err", 32'(err), 32'(e_err));
      check("end_cpu_hold", 32'(cpu_hold), 32'd0);
      check("n_strobes", 32'(n_strobe), 32'(e_n));
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      if (e_n > 0) check("last_addr_held", 32'(bus.IAddress), 32'(e_n - 1));
      if (gap == 0) check("session_cycles", 32'(c1 - c0), 32'(2 + 3 * e_n));
      strobes_end = n_strobe;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ready_low_after_end", 32'(bus.byte_ready), 32'd0);
      end
      bus.byte_valid = 1'b0;
      check("no_strobe_after_end", 32'(n_strobe), 32'(strobes_end));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int count;
      int gap;
      bit poke;
      int kind;
      bit exp_done;
      bit exp_err;
      int exp_n;
   } vec_t;

   vec_t vecs[8];

   initial begin
      bit m_err;
      int m_n;
      vecs[0] = '{count: 3,  gap: 0,  poke: 0, kind: 1, exp_done: 1, exp_err: 0, exp_n: 3};
      vecs[1] = '{count: 3,  gap: 45, poke: 0, kind: 1, exp_done: 1, exp_err: 0, exp_n: 3};
      vecs[2] = '{count: 0,  gap: 0,  poke: 0, kind: 0, exp_done: 1, exp_err: 0, exp_n: 0};
      vecs[3] = '{count: 64, gap: 0,  poke: 0, kind: 0, exp_done: 1, exp_err: 0, exp_n: 64};
      vecs[4] = '{count: 65, gap: 0,  poke: 0, kind: 0, exp_done: 0, exp_err: 1, exp_n: 0};
      vecs[5] = '{count: 5,  gap: 20, poke: 1, kind: 0, exp_done: 1, exp_err: 0, exp_n: 5};
      vecs[6] = '{count: 1,  gap: 0,  poke: 0, kind: 0, exp_done: 1, exp_err: 0, exp_n: 1};
      vecs[7] = '{count: 64, gap: 30, poke: 0, kind: 0, exp_done: 1, exp_err: 0, exp_n: 64};

      rst = 1'b1;
      start = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_data = 8'h55;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.byte_ready), 32'd0);
      check("rst_strobe", 32'(bus.InsMemRW), 32'd0);
      check("rst_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
      check("rst_addr_data", {bus.IAddress, bus.IData}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      bus.byte_valid = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 8; v++)
         run_session(vecs[v].count, vecs[v].gap, vecs[v].poke, vecs[v].kind,
                     1'b1, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_n);

      // Reset mid-session: two words written, third word's high byte lost to reset.
      build_stream(4, 0);
      model_expect(m_err, m_n);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      n_strobe = 0;
      pulse_start();
      send_bytes(7, 0, 1'b0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = stream_q[7];
      rst = 1'b1;
      @(negedge clk);
      check("midrst_no_strobe", 32'(bus.InsMemRW), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(bus.byte_ready), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      bus.byte_valid = 1'b0;
      @(negedge clk);
      check("midrst_strobes", 32'(n_strobe), 32'd2);
      check("midrst_exp_q", 32'(exp_q.size()), 32'd0);
      run_session(1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1);

      for (int r = 0; r < 5; r++)
         run_session($urandom_range(0, 70), $urandom_range(0, 50), 1'b0, 0,
                     1'b0, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer side of the CPU instruction memory: accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and issues single-cycle write strobes (`InsMemRW`=1, `IAddress`, `IData`) into the 64-entry instruction store. It replaces the simulation-only file preload for hardware bring-up. It sits between the host byte link (UART receiver) and the instruction memory write port, and holds the CPU stalled while a load is in progress.

## Interface
Parameters:
- `DEPTH`, 64, number of 16-bit instruction words in the target memory; legal load sizes are 0..DEPTH.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load session; sampled only in IDLE, DONE or ERR.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; transfer when `byte_valid && byte_ready`.
- `InsMemRW`  out  1  instruction memory write strobe (1 = write); high for exactly one cycle per word.
- `IAddress`  out  16  word address of the write; zero-extended counter.
- `IData`  out  16  instruction word being written.
- `busy`  out  1  session active (any state other than IDLE/DONE/ERR).
- `cpu_hold`  out  1  equals `busy`; stalls CPU PC and fetch.
- `done`  out  1  level: last session completed; cleared by `start` or `rst`.
- `err`  out  1  level: header count exceeded `DEPTH`; cleared by `start` or `rst`.

## Operation
- Stream format, little-endian: `count` low byte, `count` high byte, then `count` words, each low byte then high byte. Word k goes to address k.
- States: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, DONE, ERR.
- IDLE/DONE/ERR + `start` -> HDR_LO; clears `done`, `err`, word counter, `IAddress`.
- HDR_LO: on transfer, latch `count[7:0]` -> HDR_HI.
- HDR_HI: on transfer, latch `count[15:8]`; if full count == 0 -> DONE; if count > DEPTH -> ERR; else -> DAT_LO.
- DAT_LO: on transfer, latch `IData[7:0]` -> DAT_HI.
- DAT_HI: on transfer, latch `IData[15:8]` -> WRITE.
- WRITE (one cycle): `InsMemRW`=1 with `IAddress`=counter and `IData` stable. On exit, counter+1; if counter+1 == count -> DONE, else -> DAT_LO.
- DONE: `done`=1. ERR: `err`=1. No further bytes are accepted in either; no memory writes.
- `byte_ready`=1 only in HDR_LO, HDR_HI, DAT_LO, DAT_HI. 0 in WRITE, IDLE, DONE, ERR.
- `start` while `busy` is ignored.
- Bytes presented while `byte_ready`=0 are not consumed. Upstream holds them.
- Counter is 7 bits wide; `IAddress` = {9'b0, counter}. Counter never exceeds DEPTH-1 on a strobe, so it does not wrap.

## Timing
- Reset: state IDLE; `byte_ready`, `InsMemRW`, `busy`, `cpu_hold`, `done`, `err` = 0; `IAddress`, `IData`, counter, count = 0.
- `rst` mid-session: return to IDLE on the next edge. Words already written stay in memory. A pending WRITE is dropped (`InsMemRW` is 0 in the cycle after the reset edge).
- All outputs are registered or decoded from state only. No combinational path from `byte_valid` to `byte_ready`.
- Throughput: with `byte_valid` held high, one word every 3 cycles (DAT_LO, DAT_HI, WRITE).
- Latency: the strobe is asserted in the cycle after the edge that accepts the high byte.
- `done` rises in the cycle after the final WRITE, or after HDR_HI for count 0. `busy` falls in the same cycle.
- `IAddress`/`IData` hold their last values after DONE/ERR until the next `start`.

## Test plan
- Reset: assert `rst` 2 cycles with `byte_valid`=1 -> all outputs 0, no transfer.
- Normal load: `start`, stream 03 00 | 34 12 | 78 56 | BC 9A -> exactly three strobes: (addr 0, 0x1234), (1, 0x5678), (2, 0x9ABC). Then `done`=1, `busy`=0, and `byte_ready` stays 0 afterwards.
- Backpressure/gaps: same stream with `byte_valid` randomly low, and bytes offered during WRITE -> identical writes. No byte is lost or duplicated. `byte_ready`=0 in every WRITE cycle.
- Boundaries:
  - count=0 (00 00) -> DONE with no strobe.
  - count=64 -> 64 strobes, addresses 0..63, last at 63.
  - count=65 (41 00) -> ERR, `err`=1, no strobe, `byte_ready`=0.
- Reset mid-session: `rst` after 2 of 4 words -> IDLE, `busy`=0. A new `start` with 01 00 EF BE -> writes 0xBEEF at address 0.
- `start` pulsed during an active load -> ignored; the session completes normally.
